// File: rtl/fir_filter_param.sv
// Sequential alternating-sign FIR: one multiply-accumulate per cycle over NTAPS taps,
// saturated magnitude output, one-deep queued sample/coefficient strobes with overrun flagging.
module fir_filter_param #(
  parameter int unsigned NTAPS      = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned COEF_W     = 16,
  parameter int unsigned SAMPLE_CNT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [COEF_W-1:0] fir_coefficient,
  input  logic              load_coeff,
  input  logic              data_ready,
  output logic              samples_done,
  output logic              modwait,
  output logic [DATA_W-1:0] fir_out,
  output logic              err
);
  localparam int unsigned KW = $clog2(NTAPS);
  localparam int unsigned PW = DATA_W + COEF_W;
  localparam int unsigned AW = PW + KW + 1;
  localparam int unsigned CW = $clog2(SAMPLE_CNT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, MAC, DONE} state_t;
  state_t state, state_nxt;

  logic                 dr_q, lc_q, dr_pend, lc_pend, ovr_seen;
  logic                 dr_edge, lc_edge, overrun;
  logic                 start_mac, do_load, do_mac, do_done, last_k;
  logic [DATA_W-1:0]    tap  [NTAPS];
  logic [COEF_W-1:0]    coef [NTAPS];
  logic [KW-1:0]        k, coef_ptr;
  logic [CW-1:0]        cnt, cnt_inc;
  logic signed [AW-1:0] acc, term, res;
  logic [AW-1:0]        mag;
  logic [PW-1:0]        prod;
  logic                 ovf;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dr_pend)      state_nxt = MAC;
        else if (lc_pend) state_nxt = LOAD;
      end
      LOAD:    state_nxt = IDLE;
      MAC:     if (last_k) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_mac = 1'b0;
    do_load   = 1'b0;
    do_mac    = 1'b0;
    do_done   = 1'b0;
    case (state)
      IDLE:    start_mac = dr_pend;
      LOAD:    do_load   = 1'b1;
      MAC:     do_mac    = 1'b1;
      DONE:    do_done   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    dr_edge = data_ready & ~dr_q;
    lc_edge = load_coeff & ~lc_q;
    overrun = (dr_edge & dr_pend) | (lc_edge & lc_pend);
    last_k  = (k == KW'(NTAPS - 1));
    prod    = PW'(tap[k]) * PW'(coef[k]);
    term    = AW'(prod);
    // Arithmetic shift floors negative results toward minus infinity.
    res     = acc >>> COEF_W;
    mag     = res[AW-1] ? AW'(-res) : AW'(res);
    ovf     = |(mag >> DATA_W);
    cnt_inc = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dr_q         <= 1'b0;
      lc_q         <= 1'b0;
      dr_pend      <= 1'b0;
      lc_pend      <= 1'b0;
      ovr_seen     <= 1'b0;
      k            <= '0;
      coef_ptr     <= '0;
      cnt          <= '0;
      acc          <= '0;
      modwait      <= 1'b0;
      samples_done <= 1'b0;
      fir_out      <= '0;
      err          <= 1'b0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        tap[i]  <= '0;
        coef[i] <= '0;
      end
    end else begin
      dr_q         <= data_ready;
      lc_q         <= load_coeff;
      modwait      <= (state_nxt != IDLE);
      samples_done <= 1'b0;

      // An edge landing on an already-set flag is dropped; the flag is never re-armed by it.
      if (start_mac)             dr_pend <= 1'b0;
      if (dr_edge && !dr_pend)   dr_pend <= 1'b1;
      if (do_load)               lc_pend <= 1'b0;
      if (lc_edge && !lc_pend)   lc_pend <= 1'b1;

      if (start_mac)    ovr_seen <= overrun;
      else if (overrun) ovr_seen <= 1'b1;

      if (overrun) err <= 1'b1;

      if (start_mac) begin
        for (int unsigned i = NTAPS - 1; i > 0; i--) tap[i] <= tap[i-1];
        tap[0] <= sample_data;
        acc    <= '0;
        k      <= '0;
      end

      if (do_mac) begin
        acc <= k[0] ? acc - term : acc + term;
        k   <= k + 1'b1;
      end

      if (do_load) begin
        coef[coef_ptr] <= fir_coefficient;
        coef_ptr       <= (coef_ptr == KW'(NTAPS - 1)) ? '0 : coef_ptr + 1'b1;
        cnt            <= '0;
        err            <= overrun;
      end

      if (do_done) begin
        fir_out <= ovf ? '1 : mag[DATA_W-1:0];
        err     <= ovf | ovr_seen | overrun;
        if (cnt_inc == CW'(SAMPLE_CNT)) begin
          samples_done <= 1'b1;
          cnt          <= '0;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_filter_param.sv
// Bench for fir_filter_param: directed tables, hand-built corner sequences and a
// randomized run against an arithmetic reference model of the alternating-sign FIR.
module tb_fir_filter_param;
  localparam int NTAPS = 4;
  localparam int SCNT  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_data;
  logic [15:0] fir_coefficient;
  logic        load_coeff;
  logic        data_ready;
  logic        samples_done;
  logic        modwait;
  logic [15:0] fir_out;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;

  fir_filter_param #(
    .NTAPS(NTAPS), .DATA_W(16), .COEF_W(16), .SAMPLE_CNT(SCNT)
  ) dut (
    .clk(clk), .rst(rst), .sample_data(sample_data), .fir_coefficient(fir_coefficient),
    .load_coeff(load_coeff), .data_ready(data_ready), .samples_done(samples_done),
    .modwait(modwait), .fir_out(fir_out), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] sample;
    logic [15:0] exp_out;
    logic        exp_err;
    logic        exp_done;
  } vec_t;

  vec_t tab_a[10];
  vec_t tab_b[5];
  vec_t dummy;

  // Reference model state: taps newest-first, coefficient write pointer, processed-sample count.
  logic [15:0] m_coef[NTAPS];
  logic [15:0] m_tap[NTAPS];
  int          m_ptr;
  int          m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < NTAPS; i++) begin
      m_coef[i] = '0;
      m_tap[i]  = '0;
    end
    m_ptr = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_load(input logic [15:0] c);
    m_coef[m_ptr] = c;
    m_ptr = (m_ptr + 1) % NTAPS;
    m_cnt = 0;
  endfunction

  function automatic void model_sample(input logic [15:0] d, output logic [15:0] o,
                                       output logic e, output logic done);
    longint sum, p, res, mg;
    for (int i = NTAPS - 1; i > 0; i--) m_tap[i] = m_tap[i-1];
    m_tap[0] = d;
    sum = 0;
    for (int i = 0; i < NTAPS; i++) begin
      p = longint'(m_tap[i]) * longint'(m_coef[i]);
      sum = (i % 2 == 0) ? sum + p : sum - p;
    end
    res = sum / 65536;
    if (sum < 0 && (sum % 65536) != 0) res = res - 1;
    mg = (res < 0) ? -res : res;
    if (mg > 65535) begin
      o = 16'hFFFF;
      e = 1'b1;
    end else begin
      o = 16'(mg);
      e = 1'b0;
    end
    m_cnt = m_cnt + 1;
    done = (m_cnt == SCNT);
    if (done) m_cnt = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic wait_done(input bit lc_mid, input logic [15:0] lc_val,
                           output logic [15:0] o, output logic e, output int dn,
                           output int mw, output bit to);
    bit seen, lc_sent;
    seen = 0; lc_sent = 0;
    dn = 0; mw = 0; to = 1; o = '0; e = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (load_coeff) load_coeff = 1'b0;
      if (samples_done) dn++;
      if (modwait) begin
        mw++;
        seen = 1;
        if (lc_mid && !lc_sent) begin
          fir_coefficient = lc_val;
          load_coeff      = 1'b1;
          lc_sent         = 1;
        end
      end else if (seen) begin
        o  = fir_out;
        e  = err;
        to = 0;
        break;
      end
    end
    load_coeff = 1'b0;
  endtask

  task automatic load_coef(input logic [15:0] c);
    fir_coefficient = c;
    load_coeff = 1'b1;
    tick();
    load_coeff = 1'b0;
    repeat (4) tick();
    model_load(c);
    check("load_clears_err", err, 0);
  endtask

  task automatic do_sample(input string tag, input logic [15:0] d, input bit lc_mid,
                           input logic [15:0] lc_val, input bit from_tab, input vec_t v);
    logic [15:0] o, mo;
    logic        e, me, md;
    int          dn, mw;
    bit          to;
    model_sample(d, mo, me, md);
    if (from_tab) begin
      mo = v.exp_out;
      me = v.exp_err;
      md = v.exp_done;
    end
    sample_data = d;
    data_ready  = 1'b1;
    tick();
    data_ready  = 1'b0;
    wait_done(lc_mid, lc_val, o, e, dn, mw, to);
    if (lc_mid) model_load(lc_val);
    check({tag, "_timeout"}, to, 0);
    check({tag, "_fir_out"}, o, mo);
    check({tag, "_err"}, e, me);
    check({tag, "_samples_done"}, dn, md);
    check({tag, "_modwait_cycles"}, mw, NTAPS + 1);
    repeat (4) tick();
  endtask

  initial begin
    logic [15:0] o, mo1, mo2, mo;
    logic        e, me1, me2, md1, md2, me, md;
    int          dn, mw, busy;
    bit          to;

    tab_a[0] = '{16'd100, 16'd50,  1'b0, 1'b0};
    tab_a[1] = '{16'd200, 16'd50,  1'b0, 1'b0};
    tab_a[2] = '{16'd0,   16'd50,  1'b0, 1'b1};
    tab_a[3] = '{16'd0,   16'd50,  1'b0, 1'b0};
    tab_a[4] = '{16'd0,   16'd100, 1'b0, 1'b0};
    tab_a[5] = '{16'd0,   16'd0,   1'b0, 1'b1};
    tab_a[6] = '{16'd200, 16'd100, 1'b0, 1'b0};
    tab_a[7] = '{16'd100, 16'd50,  1'b0, 1'b0};
    tab_a[8] = '{16'd1,   16'd50,  1'b0, 1'b1};
    tab_a[9] = '{16'd0,   16'd51,  1'b0, 1'b0};

    tab_b[0] = '{16'hFFFF, 16'hFFFE, 1'b0, 1'b0};
    tab_b[1] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0};
    tab_b[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1};
    tab_b[3] = '{16'h0000, 16'hFFFF, 1'b1, 1'b0};
    tab_b[4] = '{16'h0000, 16'hFFFE, 1'b0, 1'b0};
    dummy    = '{16'h0, 16'h0, 1'b0, 1'b0};

    rst = 1'b1; sample_data = '0; fir_coefficient = '0; load_coeff = 1'b0; data_ready = 1'b0;
    model_reset();
    tick(); tick();
    check("reset_samples_done", samples_done, 0);
    check("reset_modwait", modwait, 0);
    check("reset_fir_out", fir_out, 0);
    check("reset_err", err, 0);
    rst = 1'b0;
    tick();

    // Half-scale coefficients: basic, reversed-order and floor-rounding cases.
    for (int i = 0; i < NTAPS; i++) load_coef(16'h8000);
    for (int i = 0; i < 10; i++) do_sample($sformatf("tab_a%0d", i), tab_a[i].sample, 0, '0, 1, tab_a[i]);

    // Reset in the middle of a computation aborts it without an output update.
    sample_data = 16'd7;
    data_ready  = 1'b1;
    tick();
    data_ready  = 1'b0;
    tick(); tick();
    check("rst_pre_busy", modwait, 1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_mid_modwait", modwait, 0);
    check("rst_mid_fir_out", fir_out, 0);
    check("rst_mid_err", err, 0);
    check("rst_mid_samples_done", samples_done, 0);
    busy = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (modwait) busy++;
    end
    check("rst_abort_idle", busy, 0);
    model_reset();

    // Full-scale coefficients: saturation boundary and err clearing.
    for (int i = 0; i < NTAPS; i++) load_coef(16'hFFFF);
    for (int i = 0; i < 5; i++) do_sample($sformatf("tab_b%0d", i), tab_b[i].sample, 0, '0, 1, tab_b[i]);

    // Overrun: second sample queued, third edge arrives while it is still pending.
    model_sample(16'd10, mo1, me1, md1);
    model_sample(16'd20, mo2, me2, md2);
    sample_data = 16'd10;
    data_ready  = 1'b1;
    tick();
    data_ready  = 1'b0;
    tick();
    sample_data = 16'd20;
    data_ready  = 1'b1;
    tick();
    data_ready  = 1'b0;
    tick();
    check("ovr_err_before", err, 0);
    data_ready  = 1'b1;
    tick();
    data_ready  = 1'b0;
    check("ovr_err_immediate", err, 1);
    wait_done(0, '0, o, e, dn, mw, to);
    check("ovr1_timeout", to, 0);
    check("ovr1_fir_out", o, mo1);
    check("ovr1_err", e, 1);
    check("ovr1_samples_done", dn, md1);
    wait_done(0, '0, o, e, dn, mw, to);
    check("ovr2_timeout", to, 0);
    check("ovr2_fir_out", o, mo2);
    check("ovr2_err", e, me2);
    check("ovr2_samples_done", dn, md2);
    check("ovr2_modwait_cycles", mw, NTAPS + 1);
    repeat (4) tick();

    // Sample count restarts on a coefficient load.
    load_coef(16'h4000);
    do_sample("cnt_a", 16'd300, 0, '0, 0, dummy);
    do_sample("cnt_b", 16'd400, 0, '0, 0, dummy);
    load_coef(16'h2000);
    do_sample("cnt_c", 16'd500, 0, '0, 0, dummy);
    do_sample("cnt_d", 16'd600, 0, '0, 0, dummy);
    do_sample("cnt_e", 16'd700, 0, '0, 0, dummy);

    // Simultaneous sample and coefficient edges: sample uses the old coefficients.
    model_sample(16'd1234, mo, me, md);
    sample_data     = 16'd1234;
    fir_coefficient = 16'hC000;
    data_ready      = 1'b1;
    load_coeff      = 1'b1;
    tick();
    data_ready      = 1'b0;
    load_coeff      = 1'b0;
    wait_done(0, '0, o, e, dn, mw, to);
    model_load(16'hC000);
    check("simul_timeout", to, 0);
    check("simul_fir_out", o, mo);
    check("simul_err", e, me);
    check("simul_samples_done", dn, md);
    repeat (4) tick();
    do_sample("simul_next", 16'd4321, 0, '0, 0, dummy);

    // Randomized traffic, including coefficient loads issued during a computation.
    for (int it = 0; it < 40; it++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 2) load_coef(16'($urandom));
      else do_sample($sformatf("rnd%0d", it), 16'($urandom), r == 9, 16'($urandom), 0, dummy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
